int_sequencer: RTL and testbench

Interrupt and reset sequencer for the 6502 core. It runs the fixed 7-cycle RST/NMI/IRQ/BRK entry sequence: two dummy PC reads, three stack pushes (PCH, PCL, P), and a two-byte vector fetch. While it runs, it owns the core's address bus, R/W and data-out. It sits beside the microcode sequencer in `CPU`, which hands over the bus while `seq_busy` is high and loads PC from `pc_vec` on `pc_load`.

---
 rtl/int_sequencer_pkg.sv | 44 ++++
 rtl/int_sequencer_nmi_edge_detect.sv | 30 +++
 rtl/int_sequencer.sv | 177 +++++++++++++++++
 tb/tb_int_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the 6502 interrupt/reset entry sequencer.
// State and source encodings, bus-drive payload and the pushed-status helper.
package int_sequencer_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned P_BIT_B = 4;
  localparam int unsigned P_BIT_U = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D0   = 3'd1,
    ST_D1   = 3'd2,
    ST_PH   = 3'd3,
    ST_PL   = 3'd4,
    ST_PP   = 3'd5,
    ST_VL   = 3'd6,
    ST_VH   = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } int_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
  } bus_drive_t;

  // Status byte as it goes onto the stack: unused bit forced high, B only for BRK.
  function automatic logic [DATA_W-1:0] push_status(input logic [DATA_W-1:0] p,
                                                    input logic              is_brk);
    logic [DATA_W-1:0] r;
    r          = p;
    r[P_BIT_U] = 1'b1;
    r[P_BIT_B] = is_brk;
    return r;
  endfunction

endpackage

// File: rtl/int_sequencer_nmi_edge_detect.sv
// NMI falling-edge detector with a sticky pending flag.
// A new edge in the same cycle as a clear keeps the flag set.
module int_sequencer_nmi_edge_detect (
  input  logic clk,
  input  logic RST,
  input  logic NMI,
  input  logic clr,
  output logic pending
);

  logic nmi_prev_q;
  logic pending_q, pending_d;

  always_comb begin
    pending_d = (nmi_prev_q & ~NMI) | (pending_q & ~clr);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      nmi_prev_q <= 1'b1;
      pending_q  <= 1'b0;
    end else begin
      nmi_prev_q <= NMI;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/int_sequencer.sv
// 7-cycle RST/NMI/IRQ/BRK entry sequencer: dummy reads, three pushes, vector fetch.
// Owns the core bus while seq_busy is high; hands PC back through pc_load/pc_vec.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RST    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        NMI,
  input  logic        IRQ,
  input  logic        RDY,
  input  logic        sync,
  input  logic        brk_req,
  input  logic        flag_i,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  d_in,
  output logic        seq_busy,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        sp_dec,
  output logic        set_i,
  output logic        pc_load,
  output logic [15:0] pc_vec
);

  seq_state_e        state_q, state_d;
  int_src_e          src_q, src_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic [DATA_W-1:0] vec_lo_q, vec_lo_d;
  logic [ADDR_W-1:0] pc_vec_q, pc_vec_d;
  logic              pc_load_q, pc_load_d;
  logic              nmi_pending;
  logic              nmi_clr;
  logic              adv;
  logic              is_rst;
  logic [DATA_W-1:0] push_data;
  bus_drive_t        bus;

  int_sequencer_nmi_edge_detect u_nmi_edge (
    .clk     (clk),
    .RST     (RST),
    .NMI     (NMI),
    .clr     (nmi_clr),
    .pending (nmi_pending)
  );

  // Writes never stall; reads wait for RDY.
  assign adv    = RDY | ~rw;
  assign is_rst = (src_q == SRC_RST);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_D0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    vec_d     = vec_q;
    vec_lo_d  = vec_lo_q;
    pc_vec_d  = pc_vec_q;
    pc_load_d = 1'b0;
    nmi_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nmi_pending && sync) begin
          src_d   = SRC_NMI;
          state_d = ST_D0;
        end else if (!IRQ && !flag_i && sync) begin
          src_d   = SRC_IRQ;
          state_d = ST_D0;
        end else if (brk_req) begin
          src_d   = SRC_BRK;
          state_d = ST_D0;
        end
      end
      ST_D0: if (adv) state_d = ST_D1;
      ST_D1: if (adv) state_d = ST_PH;
      ST_PH: if (adv) state_d = ST_PL;
      ST_PL: if (adv) state_d = ST_PP;
      ST_PP: begin
        // Vector is fixed here; a late NMI hijacks a BRK/IRQ entry.
        if (adv) begin
          state_d = ST_VL;
          if (is_rst) begin
            vec_d = VEC_RST;
          end else if (nmi_pending) begin
            vec_d   = VEC_NMI;
            nmi_clr = 1'b1;
          end else begin
            vec_d = VEC_IRQ;
          end
        end
      end
      ST_VL: begin
        if (adv) begin
          state_d  = ST_VH;
          vec_lo_d = d_in;
        end
      end
      ST_VH: begin
        if (adv) begin
          state_d   = ST_IDLE;
          pc_vec_d  = {d_in, vec_lo_q};
          pc_load_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      src_q     <= SRC_RST;
      vec_q     <= VEC_RST;
      vec_lo_q  <= '0;
      pc_vec_q  <= '0;
      pc_load_q <= 1'b0;
    end else begin
      src_q     <= src_d;
      vec_q     <= vec_d;
      vec_lo_q  <= vec_lo_d;
      pc_vec_q  <= pc_vec_d;
      pc_load_q <= pc_load_d;
    end
  end

  always_comb begin
    bus       = '{addr: pc_in, data: '0, rw: 1'b1};
    seq_busy  = 1'b1;
    sp_dec    = 1'b0;
    set_i     = 1'b0;
    push_data = '0;
    case (state_q)
      ST_PH: push_data = pc_in[15:8];
      ST_PL: push_data = pc_in[7:0];
      ST_PP: push_data = push_status(p_in, src_q == SRC_BRK);
      default: push_data = '0;
    endcase
    case (state_q)
      ST_IDLE: begin
        seq_busy = 1'b0;
        bus.addr = '0;
      end
      ST_PH, ST_PL, ST_PP: begin
        // Reset entry runs the pushes as reads so the stack is left untouched.
        bus.addr = {STACK_PAGE, sp_in};
        bus.rw   = is_rst;
        bus.data = is_rst ? '0 : push_data;
        sp_dec   = RDY | ~is_rst;
      end
      ST_VL: begin
        bus.addr = vec_q;
        set_i    = RDY;
      end
      ST_VH: bus.addr = ADDR_W'(vec_q + 16'd1);
      default: bus.addr = pc_in;
    endcase
  end

  assign addr_out = bus.addr;
  assign data_out = bus.data;
  assign rw       = bus.rw;
  assign pc_load  = pc_load_q;
  assign pc_vec   = pc_vec_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: per-cycle bus trace predicted from the
// entry-sequence rules, with random PC/SP/P/vectors, RDY stalls and NMI edges.
module tb_int_sequencer;

  localparam int K_RST = 0;
  localparam int K_NMI = 1;
  localparam int K_IRQ = 2;
  localparam int K_BRK = 3;

  logic        clk;
  logic        RST, NMI, IRQ, RDY, sync, brk_req, flag_i;
  logic [15:0] pc_in;
  logic [7:0]  sp_in, p_in, d_in;
  logic        seq_busy, rw, sp_dec, set_i, pc_load;
  logic [15:0] addr_out, pc_vec;
  logic [7:0]  data_out;

  logic [7:0]  vec_mem [0:5];
  logic        m_prev, m_pend, m_clr;
  logic [7:0]  sp_m;
  int          n_checks, n_pass;

  int_sequencer dut (
    .clk      (clk),
    .RST      (RST),
    .NMI      (NMI),
    .IRQ      (IRQ),
    .RDY      (RDY),
    .sync     (sync),
    .brk_req  (brk_req),
    .flag_i   (flag_i),
    .pc_in    (pc_in),
    .sp_in    (sp_in),
    .p_in     (p_in),
    .d_in     (d_in),
    .seq_busy (seq_busy),
    .addr_out (addr_out),
    .data_out (data_out),
    .rw       (rw),
    .sp_dec   (sp_dec),
    .set_i    (set_i),
    .pc_load  (pc_load),
    .pc_vec   (pc_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector ROM at FFFA..FFFF, everything else reads as NOP.
  assign d_in = (addr_out[15:3] == 13'h1FFF && addr_out[2:0] >= 3'd2) ?
                vec_mem[addr_out[2:0] - 3'd2] : 8'hEA;

  // NMI is remembered from a high-to-low step until an entry consumes it.
  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      m_prev <= 1'b1;
      m_pend <= 1'b0;
    end else begin
      m_prev <= NMI;
      m_pend <= (m_prev & ~NMI) | (m_pend & ~m_clr);
    end
  end

  task automatic run_seq(input int kind, input logic [7:0] nmi_pat,
                         input int stall_k, input int stall_n, input int rst_at);
    int          k, cyc, stall_left;
    logic        adv, exp_rw, is_push, exp_sp, exp_seti;
    logic [15:0] exp_addr, vec_m, exp_vec;
    logic [7:0]  exp_data, stat;
    k = 0; cyc = 0; stall_left = stall_n; vec_m = 16'hFFFE;
    stat    = p_in | 8'h20;
    stat[4] = (kind == K_BRK);
    if (kind != K_RST) begin
      sync    = (kind == K_NMI) || (kind == K_IRQ);
      IRQ     = (kind == K_IRQ) ? 1'b0 : 1'b1;
      brk_req = (kind == K_BRK);
      #2;
      n_checks++;
      if ({seq_busy, rw, addr_out, data_out, sp_dec, set_i} !== {1'b0, 1'b1, 16'h0, 8'h0, 1'b0, 1'b0})
        $display("FAIL start_idle kind=%0d: got busy=%b rw=%b addr=%h data=%h spd=%b seti=%b, want idle outputs",
                 kind, seq_busy, rw, addr_out, data_out, sp_dec, set_i);
      else n_pass++;
      @(posedge clk); @(negedge clk);
      sync = 1'b0; IRQ = 1'b1; brk_req = 1'b0;
    end
    while (k < 7 && cyc < 40) begin
      cyc++;
      NMI = nmi_pat[k];
      RDY = !(k == stall_k && stall_left > 0);
      if (k == rst_at) begin
        RST = 1'b0; RDY = 1'b1;
        #2;
        n_checks++;
        if ({seq_busy, rw, addr_out, data_out, sp_dec, set_i, pc_load} !==
            {1'b1, 1'b1, pc_in, 8'h00, 1'b0, 1'b0, 1'b0})
          $display("FAIL rst_abort: got busy=%b rw=%b addr=%h data=%h spd=%b seti=%b pcl=%b, want 1 1 %h 00 0 0 0",
                   seq_busy, rw, addr_out, data_out, sp_dec, set_i, pc_load, pc_in);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        NMI = 1'b1;
        return;
      end
      is_push = (k >= 2 && k <= 4);
      exp_rw  = !(is_push && kind != K_RST);
      adv     = RDY || !exp_rw;
      case (k)
        2:       begin exp_addr = {8'h01, sp_m}; exp_data = (kind == K_RST) ? 8'h00 : pc_in[15:8]; end
        3:       begin exp_addr = {8'h01, sp_m}; exp_data = (kind == K_RST) ? 8'h00 : pc_in[7:0]; end
        4:       begin exp_addr = {8'h01, sp_m}; exp_data = (kind == K_RST) ? 8'h00 : stat; end
        5:       begin exp_addr = vec_m; exp_data = 8'h00; end
        6:       begin exp_addr = vec_m + 16'd1; exp_data = 8'h00; end
        default: begin exp_addr = pc_in; exp_data = 8'h00; end
      endcase
      exp_sp   = is_push && adv;
      exp_seti = (k == 5) && RDY;
      if (k == 4 && adv) begin
        vec_m = (kind == K_RST) ? 16'hFFFC : (m_pend ? 16'hFFFA : 16'hFFFE);
        m_clr = (kind != K_RST) && m_pend;
      end
      #2;
      n_checks++;
      if ({seq_busy, rw, addr_out, data_out, sp_dec, set_i, pc_load} !==
          {1'b1, exp_rw, exp_addr, exp_data, exp_sp, exp_seti, 1'b0})
        $display("FAIL seq kind=%0d step=%0d: got busy=%b rw=%b addr=%h data=%h spd=%b seti=%b pcl=%b, want 1 %b %h %h %b %b 0",
                 kind, k, seq_busy, rw, addr_out, data_out, sp_dec, set_i, pc_load,
                 exp_rw, exp_addr, exp_data, exp_sp, exp_seti);
      else n_pass++;
      @(posedge clk);
      if (!RDY) stall_left--;
      if (exp_sp) sp_m--;
      if (adv) k++;
      @(negedge clk);
      m_clr = 1'b0;
      sp_in = sp_m;
    end
    NMI = 1'b1; RDY = 1'b1;
    if (k < 7) begin
      n_checks++;
      $display("FAIL seq_timeout kind=%0d: reached step %0d, want 7", kind, k);
    end
    exp_vec = {vec_mem[3'(vec_m[2:0] - 3'd1)], vec_mem[3'(vec_m[2:0] - 3'd2)]};
    #2;
    n_checks++;
    if ({seq_busy, pc_load, pc_vec} !== {1'b0, 1'b1, exp_vec})
      $display("FAIL pc_load kind=%0d: got busy=%b pcl=%b vec=%h, want 0 1 %h",
               kind, seq_busy, pc_load, pc_vec, exp_vec);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    #2;
    n_checks++;
    if ({seq_busy, pc_load} !== 2'b00)
      $display("FAIL pc_load_pulse kind=%0d: got busy=%b pcl=%b, want 0 0", kind, seq_busy, pc_load);
    else n_pass++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic set_core(input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] p);
    pc_in = pc; sp_m = sp; sp_in = sp; p_in = p;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    set_core(16'($urandom), 8'hFD, 8'h00);
    vec_mem[2] = 8'h34; vec_mem[3] = 8'h12;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if ({seq_busy, rw, addr_out, data_out, sp_dec, set_i, pc_load, pc_vec} !==
        {1'b1, 1'b1, pc_in, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_state: got busy=%b rw=%b addr=%h data=%h spd=%b seti=%b pcl=%b vec=%h",
               seq_busy, rw, addr_out, data_out, sp_dec, set_i, pc_load, pc_vec);
    else n_pass++;
    @(negedge clk);
    RST = 1'b1;
    run_seq(K_RST, 8'hFF, -1, 0, -1);
  endtask

  task automatic test_irq();
    set_core(16'h8000, 8'hFF, 8'h00);
    flag_i = 1'b0;
    run_seq(K_IRQ, 8'hFF, -1, 0, -1);
    flag_i = 1'b1;
  endtask

  task automatic test_irq_masked();
    flag_i = 1'b1; IRQ = 1'b0; sync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_checks++;
      if (seq_busy !== 1'b0) $display("FAIL irq_masked cycle %0d: busy=%b, want 0", i, seq_busy);
      else n_pass++;
      @(posedge clk); @(negedge clk);
    end
    IRQ = 1'b1; sync = 1'b0;
  endtask

  task automatic test_brk();
    set_core(16'($urandom), 8'($urandom), 8'hC3);
    run_seq(K_BRK, 8'hFF, -1, 0, -1);
  endtask

  task automatic test_nmi_hijack();
    set_core(16'($urandom), 8'($urandom), 8'($urandom));
    run_seq(K_BRK, 8'b1111_0111, -1, 0, -1);
    sync = 1'b1; IRQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (seq_busy !== 1'b0) $display("FAIL nmi_cleared cycle %0d: busy=%b, want 0", i, seq_busy);
      else n_pass++;
      @(posedge clk); @(negedge clk);
    end
    sync = 1'b0;
    // Second edge lands on the consuming cycle and must remain pending.
    set_core(16'($urandom), 8'($urandom), 8'($urandom));
    run_seq(K_BRK, 8'b1110_1011, -1, 0, -1);
    set_core(16'($urandom), 8'($urandom), 8'($urandom));
    run_seq(K_NMI, 8'hFF, -1, 0, -1);
  endtask

  task automatic test_rdy();
    flag_i = 1'b0;
    set_core(16'($urandom), 8'($urandom), 8'($urandom));
    run_seq(K_IRQ, 8'hFF, 5, 3, -1);
    set_core(16'($urandom), 8'($urandom), 8'($urandom));
    run_seq(K_IRQ, 8'hFF, 2, 1, -1);
    flag_i = 1'b1;
  endtask

  task automatic test_rst_abort();
    flag_i = 1'b0;
    set_core(16'($urandom), 8'($urandom), 8'($urandom));
    vec_mem[2] = 8'($urandom); vec_mem[3] = 8'($urandom);
    run_seq(K_IRQ, 8'hFF, -1, 0, 3);
    flag_i = 1'b1;
    RST = 1'b1;
    run_seq(K_RST, 8'hFF, $urandom_range(0, 6), $urandom_range(0, 2), -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      set_core(16'($urandom), 8'($urandom), 8'($urandom));
      for (int j = 0; j < 6; j++) vec_mem[j] = 8'($urandom);
      flag_i = 1'b0;
      run_seq($urandom_range(K_IRQ, K_BRK), 8'hFF, $urandom_range(0, 6), $urandom_range(0, 3), -1);
      flag_i = 1'b1;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    RST = 1'b0; NMI = 1'b1; IRQ = 1'b1; RDY = 1'b1; sync = 1'b0;
    brk_req = 1'b0; flag_i = 1'b1; m_clr = 1'b0;
    set_core(16'hC000, 8'hFD, 8'h00);
    for (int j = 0; j < 6; j++) vec_mem[j] = 8'($urandom);
    test_reset();
    test_irq();
    test_irq_masked();
    test_brk();
    test_nmi_hijack();
    test_rdy();
    test_rst_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
